// File: rtl/bcd_score_if.sv
// Score-path bus for bcd_score_accum.
// The master (the game logic) drives the requests and the slave (the accumulator)
// drives the score outputs.
//
// Handshake: add_valid is a single-cycle request with no ready. The accumulator
// accepts a request on every rising edge where add_valid is high, so back-to-back
// requests never stall. The same holds for clear and game_over.
interface bcd_score_if #(
  parameter int DIGITS = 4
);
  logic                  clear;
  logic                  add_valid;
  logic                  add_dec;
  logic [3:0]            add_val;
  logic                  game_over;
  logic [4*DIGITS-1:0]   score;
  logic                  saturated;
  logic                  bad_val;
  logic [4*DIGITS-1:0]   hiscore;
  logic                  new_record;

  modport master (
    output clear, add_valid, add_dec, add_val, game_over,
    input  score, saturated, bad_val, hiscore, new_record
  );

  modport slave (
    input  clear, add_valid, add_dec, add_val, game_over,
    output score, saturated, bad_val, hiscore, new_record
  );
endinterface

// File: rtl/bcd_score_accum.sv
// Multi-digit packed-BCD score accumulator.
// Adds or subtracts a 0..9 value at the least-significant digit. Carry or borrow
// ripples through all DIGITS digits in one cycle (legal DIGITS is 1..8).
// Overflow either clamps at all-9s (SAT_MODE=1) or wraps (SAT_MODE=0).
// Underflow always floors at zero. Both cases set the sticky saturated flag.
// Optional high-score register: define BCD_SCORE_HISCORE_EN.
module bcd_score_accum #(
  parameter int DIGITS   = 4,
  parameter bit SAT_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  bcd_score_if.slave  bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] score_q, score_d;
  logic         sat_q, sat_d;
  logic         bad_q, bad_d;

  logic [W-1:0] add_res;
  logic         add_co;
  logic [4:0]   add_t;
  logic         add_c;
  logic [W-1:0] sub_res;
  logic         sub_bo;
  logic [4:0]   sub_t;
  logic         sub_b;

  // Decimal ripple adder: add_val enters at digit 0, and each digit folds back by 10 on carry
  always_comb begin
    add_res = '0;
    add_c   = 1'b0;
    add_t   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      add_t = {1'b0, score_q[4*i +: 4]} + {4'b0000, add_c}
            + ((i == 0) ? {1'b0, bus.add_val} : 5'd0);
      if (add_t > 5'd9) begin
        add_res[4*i +: 4] = 4'(add_t - 5'd10);
        add_c             = 1'b1;
      end else begin
        add_res[4*i +: 4] = add_t[3:0];
        add_c             = 1'b0;
      end
    end
    add_co = add_c;
  end

  // Decimal ripple subtractor: a negative digit (bit 4 set) borrows 10 from the next digit
  always_comb begin
    sub_res = '0;
    sub_b   = 1'b0;
    sub_t   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sub_t = {1'b0, score_q[4*i +: 4]} - {4'b0000, sub_b}
            - ((i == 0) ? {1'b0, bus.add_val} : 5'd0);
      if (sub_t[4]) begin
        sub_res[4*i +: 4] = 4'(sub_t + 5'd10);
        sub_b             = 1'b1;
      end else begin
        sub_res[4*i +: 4] = sub_t[3:0];
        sub_b             = 1'b0;
      end
    end
    sub_bo = sub_b;
  end

  // Next score: clear beats a request; out-of-range values are rejected and flagged
  always_comb begin
    score_d = score_q;
    sat_d   = sat_q;
    bad_d   = 1'b0;
    if (bus.clear) begin
      score_d = '0;
      sat_d   = 1'b0;
    end else if (bus.add_valid) begin
      if (bus.add_val > 4'd9) begin
        bad_d = 1'b1;
      end else if (!bus.add_dec) begin
        if (add_co) begin
          sat_d   = 1'b1;
          score_d = SAT_MODE ? ALL_NINES : add_res;
        end else begin
          score_d = add_res;
        end
      end else begin
        if (sub_bo) begin
          sat_d   = 1'b1;
          score_d = '0;
        end else begin
          score_d = sub_res;
        end
      end
    end
  end

  // Score state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
      sat_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      sat_q   <= sat_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.score     = score_q;
  assign bus.saturated = sat_q;
  assign bus.bad_val   = bad_q;

`ifdef BCD_SCORE_HISCORE_EN
  logic [W-1:0] hi_q, hi_d;
  logic         rec_q, rec_d;

  // Commit the pre-update score on game_over when it strictly beats the record
  // (a plain unsigned compare is valid because the BCD digits are packed MSD-first)
  always_comb begin
    hi_d  = hi_q;
    rec_d = 1'b0;
    if (bus.game_over && (score_q > hi_q)) begin
      hi_d  = score_q;
      rec_d = 1'b1;
    end
  end

  // High-score registers; clear does not reach them, only rst does
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      rec_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      rec_q <= rec_d;
    end
  end

  assign bus.hiscore    = hi_q;
  assign bus.new_record = rec_q;
`else
  logic unused_game_over;
  assign unused_game_over = bus.game_over;
  assign bus.hiscore      = '0;
  assign bus.new_record   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_score_accum.sv
// Bench for bcd_score_accum: a saturating and a wrapping instance share one stimulus.
// Both are compared every cycle against an integer-arithmetic reference model.
module tb_bcd_score_accum;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_score_if #(.DIGITS(DIGITS)) bus_s ();
  bcd_score_if #(.DIGITS(DIGITS)) bus_w ();

  assign bus_w.clear     = bus_s.clear;
  assign bus_w.add_valid = bus_s.add_valid;
  assign bus_w.add_dec   = bus_s.add_dec;
  assign bus_w.add_val   = bus_s.add_val;
  assign bus_w.game_over = bus_s.game_over;

  bcd_score_accum #(.DIGITS(DIGITS), .SAT_MODE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  bcd_score_accum #(.DIGITS(DIGITS), .SAT_MODE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  int m_score [2];
  int m_sat   [2];
  int m_hi    [2];
  int m_bad;
  int m_rec;

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_bcd(input string tag, input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      check_eq(tag, W'(v[4*i +: 4] > 4'd9), '0);
  endtask

  task automatic check_all();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check_eq("score_sat", bus_s.score, e);
    check_eq("score_wrap", bus_w.score, to_bcd(m_score[1]));
    check_eq("saturated_sat", W'(bus_s.saturated), W'(m_sat[0]));
    check_eq("saturated_wrap", W'(bus_w.saturated), W'(m_sat[1]));
    check_eq("bad_val_sat", W'(bus_s.bad_val), W'(m_bad));
    check_eq("bad_val_wrap", W'(bus_w.bad_val), W'(m_bad));
    check_eq("hiscore_sat", bus_s.hiscore, to_bcd(m_hi[0]));
    check_eq("hiscore_wrap", bus_w.hiscore, to_bcd(m_hi[1]));
    check_eq("new_record", W'(bus_s.new_record), W'(m_rec));
    check_bcd("bcd_digit_sat", bus_s.score);
    check_bcd("bcd_digit_wrap", bus_w.score);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, predict the state after the next edge, then check it.
  task automatic apply(input logic r, input logic c, input logic v, input logic d,
                       input logic [3:0] val, input logic go);
    int t;
    rst             = r;
    bus_s.clear     = c;
    bus_s.add_valid = v;
    bus_s.add_dec   = d;
    bus_s.add_val   = val;
    bus_s.game_over = go;
    m_bad = 0;
    m_rec = 0;
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0; m_sat[k] = 0; m_hi[k] = 0;
      end
    end else begin
`ifdef BCD_SCORE_HISCORE_EN
      if (go) begin
        for (int k = 0; k < 2; k++) begin
          if (m_score[k] > m_hi[k]) begin
            m_hi[k] = m_score[k];
            if (k == 0) m_rec = 1;
          end
        end
      end
`endif
      if (c) begin
        for (int k = 0; k < 2; k++) begin
          m_score[k] = 0; m_sat[k] = 0;
        end
      end else if (v) begin
        if (val > 9) begin
          m_bad = 1;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (!d) begin
              t = m_score[k] + int'(val);
              if (t > MAXV) begin
                m_sat[k] = 1;
                t = (k == 0) ? MAXV : t - (MAXV + 1);
              end
            end else begin
              t = m_score[k] - int'(val);
              if (t < 0) begin
                m_sat[k] = 1;
                t = 0;
              end
            end
            m_score[k] = t;
          end
        end
      end
    end
    exp_q.push_back(to_bcd(m_score[0]));
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic add(input logic d, input logic [3:0] val);
    apply(1'b0, 1'b0, 1'b1, d, val, 1'b0);
  endtask

  // Clear, then climb to the target score with adds of 9 and a remainder
  task automatic reach(input int target);
    int left;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    left = target;
    while (left >= 9) begin
      add(1'b0, 4'd9);
      left -= 9;
    end
    if (left > 0) add(1'b0, 4'(left));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic c, v, d, go;
    logic [3:0] val;
    rst = 1'b1;
    bus_s.clear = 1'b0; bus_s.add_valid = 1'b0; bus_s.add_dec = 1'b0;
    bus_s.add_val = 4'd0; bus_s.game_over = 1'b0;

    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    check_eq("reset_score", bus_s.score, 16'h0000);
    check_eq("reset_sat", W'(bus_s.saturated), '0);
    check_eq("reset_hiscore", bus_s.hiscore, 16'h0000);

    reach(97);  add(1'b0, 4'd5);
    check_eq("dir_0097_plus5", bus_s.score, 16'h0102);

    reach(9998); add(1'b0, 4'd7);
    check_eq("dir_sat_9999", bus_s.score, 16'h9999);
    check_eq("dir_sat_flag", W'(bus_s.saturated), W'(1));
    check_eq("dir_wrap_0005", bus_w.score, 16'h0005);
    check_eq("dir_wrap_flag", W'(bus_w.saturated), W'(1));
    add(1'b0, 4'd3);
    check_eq("dir_sat_hold", bus_s.score, 16'h9999);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("dir_clear_score", bus_w.score, 16'h0000);
    check_eq("dir_clear_flag", W'(bus_w.saturated), '0);

    reach(100); add(1'b1, 4'd1);
    check_eq("dir_0100_minus1", bus_s.score, 16'h0099);
    reach(3); add(1'b1, 4'd8);
    check_eq("dir_floor", bus_s.score, 16'h0000);
    check_eq("dir_floor_flag", W'(bus_s.saturated), W'(1));

    reach(42); add(1'b0, 4'hC);
    check_eq("dir_bad_hold", bus_s.score, 16'h0042);
    check_eq("dir_bad_pulse", W'(bus_s.bad_val), W'(1));
    idle();
    check_eq("dir_bad_one_cycle", W'(bus_s.bad_val), '0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
    check_eq("dir_clear_wins", bus_s.score, 16'h0000);

`ifdef BCD_SCORE_HISCORE_EN
    reach(250); apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("dir_hi_0250", bus_s.hiscore, 16'h0250);
    check_eq("dir_rec_pulse", W'(bus_s.new_record), W'(1));
    reach(250); apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("dir_rec_equal", W'(bus_s.new_record), '0);
    reach(251); apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("dir_hi_0251", bus_s.hiscore, 16'h0251);
    check_eq("dir_rec_pulse2", W'(bus_s.new_record), W'(1));
    reach(300); apply(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1);
    check_eq("dir_hi_preupdate", bus_s.hiscore, 16'h0300);
`else
    reach(250); apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("dir_hi_tied", bus_s.hiscore, 16'h0000);
    check_eq("dir_rec_tied", W'(bus_s.new_record), '0);
`endif

    // Random phase, starting near the top so overflow and wrap are exercised
    reach(9990);
    for (int n = 0; n < 3000; n++) begin
      c   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 2) == 0);
      val = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if (c) val = 4'($urandom_range(0, 9));
      go  = ($urandom_range(0, 15) == 0);
      apply(1'b0, c, v, d, val, go);
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
